// File: rtl/dm_lsu.sv
// Data-memory stage: byte/half/word stores with lane enables, extending loads,
// sticky misalignment capture, a saturating store counter and a debug read port.
module dm_lsu #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemWrite,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  input  logic [3:0]       ls,
  output logic [31:0]      readdata,
  output logic             misalign,
  output logic [31:0]      fault_addr,
  output logic [15:0]      store_count,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [31:0]      dbg_data
);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             size_valid;
  logic             aligned;
  logic             commit;
  logic             fault;
  logic [3:0]       be;
  logic [31:0]      wlanes;
  logic [31:0]      rword;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic             unused_addr;

  logic             misalign_q;
  logic [31:0]      fault_addr_q;
  logic [15:0]      store_count_q;

  assign idx         = addr[IDX_W+1:2];
  assign unused_addr = ^addr[31:IDX_W+2];

  always_comb begin
    size_valid = 1'b1;
    aligned    = 1'b1;
    be         = 4'b0000;
    wlanes     = writedata;
    unique case (ls[2:0])
      3'b001: begin
        be     = 4'b0001 << addr[1:0];
        wlanes = {4{writedata[7:0]}};
      end
      3'b010: begin
        aligned = ~addr[0];
        be      = addr[1] ? 4'b1100 : 4'b0011;
        wlanes  = {2{writedata[15:0]}};
      end
      3'b100: begin
        aligned = (addr[1:0] == 2'b00);
        be      = 4'b1111;
      end
      default: begin
        size_valid = 1'b0;
        aligned    = 1'b0;
      end
    endcase
  end

  assign commit = MemWrite & size_valid & aligned;
  assign fault  = size_valid & ~aligned;

  // Load path reads the pre-edge array, so same-word writes show up next cycle.
  always_comb begin
    rword    = mem[idx];
    rbyte    = rword[{addr[1:0], 3'b000} +: 8];
    rhalf    = addr[1] ? rword[31:16] : rword[15:0];
    readdata = 32'h0;
    if (size_valid && aligned) begin
      unique case (ls[2:0])
        3'b001:  readdata = {{24{~ls[3] & rbyte[7]}}, rbyte};
        3'b010:  readdata = {{16{~ls[3] & rhalf[15]}}, rhalf};
        default: readdata = rword;
      endcase
    end
  end

  // Array deliberately has no reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q    <= 1'b0;
      fault_addr_q  <= 32'h0;
      store_count_q <= 16'h0;
    end else begin
      if (fault) begin
        misalign_q <= 1'b1;
        if (!misalign_q) fault_addr_q <= addr;
      end
      if (commit && store_count_q != 16'hFFFF) store_count_q <= store_count_q + 16'd1;
    end
  end

  assign misalign    = misalign_q;
  assign fault_addr  = fault_addr_q;
  assign store_count = store_count_q;
  assign dbg_data    = mem[dbg_idx];

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: byte-addressed reference model checked every cycle, plus
// directed literal expectations.
module tb_dm_lsu;

  localparam int NBYTES = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [3:0]  ls = 4'h0;
  logic [9:0]  dbg_idx = 10'h0;
  logic [31:0] readdata;
  logic        misalign;
  logic [31:0] fault_addr;
  logic [15:0] store_count;
  logic [31:0] dbg_data;

  int tests = 0;
  int fails = 0;
  logic check_en = 1'b0;

  dm_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .MemWrite   (MemWrite),
    .addr       (addr),
    .writedata  (writedata),
    .ls         (ls),
    .readdata   (readdata),
    .misalign   (misalign),
    .fault_addr (fault_addr),
    .store_count(store_count),
    .dbg_idx    (dbg_idx),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  // Reference model: a flat byte array plus plain counters.
  logic [7:0]  mb [NBYTES];
  logic        m_mis;
  logic [31:0] m_fault;
  logic [15:0] m_cnt;

  function automatic int nbytes(input logic [3:0] l);
    if (l[2:0] == 3'b001) return 1;
    if (l[2:0] == 3'b010) return 2;
    if (l[2:0] == 3'b100) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [3:0] l);
    int n;
    int b;
    logic [31:0] v;
    n = nbytes(l);
    b = int'(a % NBYTES);
    if (n == 0 || (b % n) != 0) return 32'h0;
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(mb[b + k]) << (8 * k));
    if (n < 4 && !l[3] && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mis   <= 1'b0;
      m_fault <= 32'h0;
      m_cnt   <= 16'h0;
    end else if (nbytes(ls) != 0) begin
      if ((int'(addr % NBYTES) % nbytes(ls)) != 0) begin
        m_mis <= 1'b1;
        if (!m_mis) m_fault <= addr;
      end else if (MemWrite) begin
        for (int k = 0; k < nbytes(ls); k++)
          mb[int'(addr % NBYTES) + k] <= writedata[8*k +: 8];
        if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && check_en) begin
      chk("model_readdata", readdata, exp_read(addr, ls));
      chk("model_dbg_data", dbg_data, exp_word(int'(dbg_idx)));
      chk("model_misalign", {31'h0, misalign}, {31'h0, m_mis});
      chk("model_fault_addr", fault_addr, m_fault);
      chk("model_store_count", {16'h0, store_count}, {16'h0, m_cnt});
    end
  end

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] l);
    @(posedge clk);
    #1;
    MemWrite  = we;
    addr      = a;
    writedata = wd;
    ls        = l;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_store_count", {16'h0, store_count}, 32'h0);
    chk("reset_misalign", {31'h0, misalign}, 32'h0);
    chk("reset_fault_addr", fault_addr, 32'h0);
    rst = 1'b1;

    // Give every word a known value, then reset; reset must not clear the array.
    for (int i = 0; i < 1024; i++) drive(1'b1, 32'(i * 4), 32'h0, 4'b0100);
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_en = 1'b1;

    drive(1'b1, 32'h10, 32'hDEADBEEF, 4'b0100);
    drive(1'b0, 32'h10, 32'h0, 4'b0100);
    dbg_idx = 10'd4;
    @(negedge clk);
    chk("sw_lw_readdata", readdata, 32'hDEADBEEF);
    chk("sw_store_count", {16'h0, store_count}, 32'h1);
    chk("sw_dbg_data", dbg_data, 32'hDEADBEEF);

    drive(1'b1, 32'h11, 32'h00000080, 4'b0001);
    drive(1'b0, 32'h11, 32'h0, 4'b0001);
    @(negedge clk);
    chk("sb_merge_dbg", dbg_data, 32'hDEAD80EF);
    chk("lb_sign", readdata, 32'hFFFFFF80);
    drive(1'b0, 32'h11, 32'h0, 4'b1001);
    @(negedge clk);
    chk("lbu_zero", readdata, 32'h00000080);
    drive(1'b0, 32'h12, 32'h0, 4'b0010);
    @(negedge clk);
    chk("lh_sign", readdata, 32'hFFFFDEAD);
    drive(1'b0, 32'h12, 32'h0, 4'b1010);
    @(negedge clk);
    chk("lhu_zero", readdata, 32'h0000DEAD);

    dbg_idx = 10'd8;
    drive(1'b1, 32'h22, 32'h12345678, 4'b0100);
    drive(1'b0, 32'h31, 32'h0, 4'b0010);
    @(negedge clk);
    chk("mis_sw_flag", {31'h0, misalign}, 32'h1);
    chk("mis_sw_fault_addr", fault_addr, 32'h22);
    chk("mis_sw_count", {16'h0, store_count}, 32'h2);
    chk("mis_sw_word8", dbg_data, 32'h0);
    chk("mis_lh_readdata", readdata, 32'h0);
    idle();
    @(negedge clk);
    chk("mis_first_kept", fault_addr, 32'h22);

    drive(1'b1, 32'h50, 32'hFFFFFFFF, 4'b0011);
    @(negedge clk);
    chk("noop_readdata", readdata, 32'h0);
    drive(1'b1, 32'h40, 32'h1, 4'b0100);
    drive(1'b1, 32'h40, 32'h2, 4'b0100);
    @(negedge clk);
    chk("rdw_old_value", readdata, 32'h1);
    drive(1'b0, 32'h40, 32'h0, 4'b0100);
    @(negedge clk);
    chk("rdw_new_value", readdata, 32'h2);
    chk("noop_count", {16'h0, store_count}, 32'h4);

    dbg_idx = 10'd0;
    drive(1'b1, 32'h1000, 32'hCAFEF00D, 4'b0100);
    idle();
    @(negedge clk);
    chk("wrap_dbg", dbg_data, 32'hCAFEF00D);

    for (int i = 0; i < 65540; i++) drive(1'b1, 32'(400 + 4 * (i % 8)), 32'(i), 4'b0100);
    idle();
    @(negedge clk);
    chk("saturate", {16'h0, store_count}, 32'hFFFF);

    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_count", {16'h0, store_count}, 32'h0);
    chk("async_rst_misalign", {31'h0, misalign}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h19C, 32'h0, 4'b0100);
    @(negedge clk);
    chk("array_survives_rst", readdata, 32'h00010003);
    idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_lsu.md
Name: dm_lsu

Overview:
- Data-memory stage for the five-stage RISC-V pipeline. Sits directly downstream of the core's MEM-stage outputs (MemWrite, aluout, writedata, ls) and returns readdata in the same cycle for the WB mux.
- Performs byte/half/word stores with byte lanes, and sign- or zero-extends loads.
- Detects misaligned accesses and suppresses them, capturing the fault.
- Provides a store counter and a debug read port.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of two.
- IDX_W, 10, word-index width; equals log2(DEPTH_WORDS).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- MemWrite  input  1  store strobe from the MEM stage.
- addr  input  32  byte address (core aluout).
- writedata  input  32  store data (core writedata); low bits are used for byte/half.
- ls  input  4  access type. [0]=byte, [1]=half, [2]=word, [3]=unsigned load.
- readdata  output  32  extended load result; combinational.
- misalign  output  1  sticky misalignment flag.
- fault_addr  output  32  address of the first misaligned access since reset.
- store_count  output  16  number of committed stores; saturating.
- dbg_idx  input  IDX_W  debug word index.
- dbg_data  output  32  raw word at dbg_idx; combinational.

Behaviour:
- Reset (rst=0, asynchronous): misalign=0, fault_addr=0, store_count=0. Array contents are not cleared by reset.
- Word index is addr[IDX_W+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH_WORDS*4.
- Valid size: exactly one of ls[2:0] is set. Any other ls value is a no-op: no write, readdata=0, no fault, no count. ls[3] is ignored for word accesses and for stores.
- Alignment:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Byte is always aligned.
- Store commit:
  - Occurs on the rising edge when MemWrite=1, size is valid and the access is aligned.
  - Byte: lane addr[1:0] is written with writedata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} are written with writedata[15:0] (little-endian).
  - Word: all four lanes are written.
  - Lanes that are not written keep their value.
- Load (combinational, zero latency):
  - Byte: selects lane addr[1:0].
  - Half: selects the halfword at addr[1].
  - Sign-extended when ls[3]=0, zero-extended when ls[3]=1.
  - Word: returned as-is.
  - A misaligned load returns 0.
- Read-during-write to the same word in the same cycle: readdata shows the pre-write contents. New data is visible from the next cycle.
- Misaligned access (size valid, alignment violated):
  - On that edge: no write, misalign<=1.
  - fault_addr<=addr only if misalign was 0, so the first fault is retained.
  - Applies to both loads and stores. Misaligned loads are detected whenever size is valid and MemWrite=0.
  - Sticky until reset.
- store_count increments by 1 per committed store and saturates at 16'hFFFF. Suppressed or no-op stores do not count.
- dbg_data = array[dbg_idx], combinational and independent of the main port. Same-cycle write is visible next cycle.
- Reset asserted mid-store: the write to the array on that edge is not guaranteed. Counters and flags are forced to 0 regardless.
- No back-pressure: the block accepts one access per cycle and never stalls the pipeline.

Test Plan:
- Word store then load: MemWrite=1, addr=0x10, ls=0100, writedata=0xDEADBEEF; next cycle MemWrite=0 -> readdata=0xDEADBEEF, store_count=1, dbg_idx=4 gives 0xDEADBEEF.
- Byte merge and extension: after the previous store, sb 0x80 to addr=0x11 (ls=0001) -> dbg word 0xDEAD80EF. lb at 0x11 -> 0xFFFFFF80. lbu at 0x11 (ls=1001) -> 0x00000080.
- Half load: lh at 0x12 (ls=0010) -> 0xFFFFDEAD. lhu (ls=1010) -> 0x0000DEAD.
- Misaligned accesses:
  - sw to addr=0x22 -> word 8 unchanged, misalign=1, fault_addr=0x22, store_count unchanged.
  - Then lh at 0x31 -> readdata=0, fault_addr remains 0x22.
- Read-during-write: word at 0x40 holds 0x1. Write 0x2 there with MemWrite=1 -> same-cycle readdata=0x1, next cycle 0x2. Wrap: sw to addr=0x1000 (DEPTH_WORDS=1024) -> dbg_idx=0 shows the data.
- Reset and saturation: drive 65540 valid stores -> store_count=0xFFFF. Pull rst low asynchronously between edges -> store_count=0, misalign=0 immediately, and previously written array words are still readable.
